// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory endpoint and its store-stream checker.
package dmem_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int STORE_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } verdict_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed storage with synchronous write and combinational read.
// Out-of-range or misaligned stores are dropped; out-of-range loads return zero.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_in_range;
  logic              w_aligned;
  logic [IDX_W-1:0]  w_idx;

  assign w_in_range = addr < ADDR_W'(DEPTH * 4);
  assign w_aligned  = (addr[1:0] == 2'b00);
  assign w_idx      = addr[IDX_W+1:2];

  always_ff @(posedge clk) begin
    if (we && w_in_range && w_aligned) begin
      r_mem[w_idx] <= wdata;
    end
  end

  assign rdata = w_in_range ? r_mem[w_idx] : '0;

endmodule

// File: rtl/dmem_checker.sv
// Data memory for the single-cycle core plus a sticky RUN/PASS/FAIL verdict over the
// store stream, with an idle-cycle timeout while in RUN.
module dmem_checker
  import dmem_pkg::*;
#(
  parameter int unsigned       DEPTH      = 64,
  parameter logic [ADDR_W-1:0] PASS_ADDR  = 32'd84,
  parameter logic [DATA_W-1:0] PASS_DATA  = 32'd7,
  parameter logic [ADDR_W-1:0] ALLOW_ADDR = 32'd80,
  parameter int unsigned       TIMEOUT    = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic [ADDR_W-1:0]      dataadr,
  input  logic [DATA_W-1:0]      writedata,
  output logic [DATA_W-1:0]      readdata,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [STORE_CNT_W-1:0] store_count,
  output logic [ADDR_W-1:0]      fail_addr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  verdict_e               r_state;
  verdict_e               w_state_next;
  logic                   w_store_fail;
  logic                   w_timeout_hit;
  logic [CNT_W-1:0]       r_cycle_cnt;
  logic [STORE_CNT_W-1:0] r_store_count;
  logic [ADDR_W-1:0]      r_fail_addr;
  logic                   r_timeout;

  // Memory writes are independent of the verdict and of reset.
  dmem_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (memwrite),
    .addr  (dataadr),
    .wdata (writedata),
    .rdata (readdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_cycle_cnt   <= '0;
      r_store_count <= '0;
      r_fail_addr   <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == RUN) begin
        if (memwrite) begin
          if (r_store_count != '1) begin
            r_store_count <= r_store_count + STORE_CNT_W'(1);
          end
        end else begin
          r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
      end
      if (w_store_fail) begin
        r_fail_addr <= dataadr;
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // A store always takes priority over the timeout on the same edge.
  always_comb begin
    w_state_next  = r_state;
    w_store_fail  = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      RUN: begin
        if (memwrite) begin
          if (dataadr == PASS_ADDR && writedata == PASS_DATA) begin
            w_state_next = PASS;
          end else if (dataadr != ALLOW_ADDR) begin
            w_state_next = FAIL;
            w_store_fail = 1'b1;
          end
        end else if (r_cycle_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_next  = FAIL;
          w_timeout_hit = 1'b1;
        end
      end
      PASS:    w_state_next = PASS;
      FAIL:    w_state_next = FAIL;
      default: w_state_next = RUN;
    endcase
  end

  always_comb begin
    done = (r_state != RUN);
    pass = (r_state == PASS);
  end

  assign timeout     = r_timeout;
  assign store_count = r_store_count;
  assign fail_addr   = r_fail_addr;

endmodule

// File: tb/tb_dmem_checker.sv
// Directed bench for dmem_checker: expectations are queued as stimulus is driven and
// popped against the DUT outputs after each clock edge.
module tb_dmem_checker;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] store_count;
  logic [31:0] fail_addr;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  dmem_checker #(
    .DEPTH      (64),
    .PASS_ADDR  (32'd84),
    .PASS_DATA  (32'd7),
    .ALLOW_ADDR (32'd80),
    .TIMEOUT    (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .readdata    (readdata),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .store_count (store_count),
    .fail_addr   (fail_addr)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
      $display("check %-14s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      memwrite = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Two-edge reset; optionally a store is presented on the first reset edge.
  task automatic do_reset(input logic st, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    reset     = 1'b1;
    memwrite  = st;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] v);
    dataadr = a;
    #1;
    push(tag, v);
    chk(readdata);
  endtask

  task automatic status_chk(input string pfx, input logic [31:0] d, input logic [31:0] p,
                            input logic [31:0] t, input logic [31:0] sc, input logic [31:0] fa);
    push({pfx, "_done"}, d);     chk(32'(done));
    push({pfx, "_pass"}, p);     chk(32'(pass));
    push({pfx, "_timeout"}, t);  chk(32'(timeout));
    push({pfx, "_count"}, sc);   chk(32'(store_count));
    push({pfx, "_failaddr"}, fa); chk(fail_addr);
  endtask

  initial begin
    // Reset state, then the passing sequence.
    do_reset(1'b0, 32'd0, 32'd0);
    status_chk("rst", 0, 0, 0, 0, 0);
    store(32'd80, 32'd5);
    push("allow_done", 32'd0); chk(32'(done));
    store(32'd84, 32'd7);
    status_chk("pass", 1, 1, 0, 2, 0);
    read_chk("rd84_pass", 32'd84, 32'd7);
    read_chk("rd80_pass", 32'd80, 32'd5);

    // Sticky PASS: further stores do not move the verdict or count.
    store(32'd100, 32'd3);
    status_chk("sticky", 1, 1, 0, 2, 0);

    // Reset one cycle after PASS, with a store to word 0 on the reset edge.
    idle(1);
    do_reset(1'b1, 32'd0, 32'h0000_00AA);
    status_chk("rst2", 0, 0, 0, 0, 0);
    read_chk("rd84_keep", 32'd84, 32'd7);
    read_chk("rd0_rstwr", 32'd0, 32'h0000_00AA);

    // Wrong data at the pass address.
    store(32'd84, 32'd9);
    status_chk("wrongdata", 1, 0, 0, 1, 84);

    // Failing store then the pass store: FAIL sticks, memory still writes.
    do_reset(1'b0, 32'd0, 32'd0);
    store(32'd100, 32'd1);
    store(32'd84, 32'd7);
    status_chk("failstick", 1, 0, 0, 1, 100);
    read_chk("rd100", 32'd100, 32'd1);
    read_chk("rd84_infail", 32'd84, 32'd7);

    // Timeout after exactly 10 idle edges.
    do_reset(1'b0, 32'd0, 32'd0);
    idle(9);
    push("to9_done", 32'd0); chk(32'(done));
    idle(1);
    status_chk("timeout", 1, 0, 1, 0, 0);

    // Store on the 10th edge overrides the timeout.
    do_reset(1'b0, 32'd0, 32'd0);
    idle(9);
    store(32'd84, 32'd7);
    status_chk("storewin", 1, 1, 0, 1, 0);

    // Out-of-range store: dropped, reads zero, fails.
    do_reset(1'b0, 32'd0, 32'd0);
    store(32'h400, 32'h1234);
    status_chk("oor", 1, 0, 0, 1, 32'h400);
    read_chk("rd400", 32'h400, 32'd0);
    read_chk("rd0_alias", 32'd0, 32'h0000_00AA);

    // Misaligned store: fails, write dropped, low bits ignored on read.
    do_reset(1'b0, 32'd0, 32'd0);
    store(32'd82, 32'h55);
    status_chk("misalign", 1, 0, 0, 1, 82);
    read_chk("rd82", 32'd82, 32'd5);
    read_chk("rd80_keep", 32'd80, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
